// File: rtl/eth_parser_pkg.sv
// ============================================================================
//  Module  : eth_parser_pkg
//  Purpose : Shared types, byte offsets and ethertype classification for the
//            L2 header parser and downstream classification stages.
//  Contents: ethertype_t, mac_addr_t, eth_class_t, eth_metadata_t,
//            parser_state_t, ETH_OFF_* byte offsets, classify_ethertype().
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_parser_pkg;

  typedef logic [15:0] ethertype_t;
  typedef logic [47:0] mac_addr_t;

  localparam ethertype_t ETHERTYPE_IPV4 = 16'h0800;
  localparam ethertype_t ETHERTYPE_ARP  = 16'h0806;
  localparam ethertype_t ETHERTYPE_IPV6 = 16'h86DD;
  localparam ethertype_t ETHERTYPE_VLAN = 16'h8100;

  // Byte offsets within the frame, counted from the first DA byte.
  localparam logic [4:0] ETH_OFF_DA         = 5'd0;
  localparam logic [4:0] ETH_OFF_SA         = 5'd6;
  localparam logic [4:0] ETH_OFF_TYPE       = 5'd12;
  localparam logic [4:0] ETH_OFF_TCI        = 5'd14;
  localparam logic [4:0] ETH_OFF_INNER_TYPE = 5'd16;
  localparam logic [4:0] ETH_HDR_LEN        = 5'd14;
  localparam logic [4:0] ETH_HDR_LEN_VLAN   = 5'd18;

  typedef enum logic [0:0] {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } parser_state_t;

  typedef struct packed {
    logic is_ipv4;
    logic is_ipv6;
    logic is_arp;
    logic is_unknown;
  } eth_class_t;

  typedef struct packed {
    mac_addr_t  dest_mac;
    mac_addr_t  src_mac;
    ethertype_t ethertype;
    logic       vlan_present;
    logic [11:0] vlan_id;
    logic [4:0] l2_header_len;
    eth_class_t cls;
  } eth_metadata_t;

  // Exactly one flag is set; an inner VLAN tag (QinQ) lands in is_unknown.
  function automatic eth_class_t classify_ethertype(input ethertype_t etype);
    eth_class_t c;
    c = '0;
    case (etype)
      ETHERTYPE_IPV4: c.is_ipv4    = 1'b1;
      ETHERTYPE_IPV6: c.is_ipv6    = 1'b1;
      ETHERTYPE_ARP:  c.is_arp     = 1'b1;
      default:        c.is_unknown = 1'b1;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_meta_reg.sv
// ============================================================================
//  Module  : eth_meta_reg
//  Purpose : Single-entry holding register with valid/ready output handshake.
//            load captures load_data and raises valid; valid drops on
//            valid & ready. The producer must only load when the slot is
//            free (valid low) or being consumed in the same cycle.
//  Ports   : clk, rst (async, active-high), load, load_data[WIDTH-1:0],
//            data[WIDTH-1:0], valid, ready
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_meta_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data  = r_data;
  assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/eth_header_parser.sv
// ============================================================================
//  Module  : eth_header_parser
//  Purpose : Byte-wide Ethernet L2 header parser. Extracts DA, SA, an optional
//            single 802.1Q tag and the EtherType into eth_metadata_t, and
//            forwards the remaining bytes as a combinational payload stream.
//  Ports   : clk, rst (async, active-high)
//            s_tdata/s_tvalid/s_tready/s_tlast : input frame stream
//            m_meta/m_meta_valid/m_meta_ready  : parsed metadata
//            p_tdata/p_tvalid/p_tready/p_tlast : payload stream
//            runt_err                          : 1-cycle runt pulse
//            stat_frames/stat_runts/stat_vlan  : saturating counters
//                                                (ETH_PARSER_STATS_EN only)
//  Config  : define ETH_PARSER_STATS_EN to add the statistics counters.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_header_parser
  import eth_parser_pkg::*;
#(
  parameter int STATS_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          s_tlast,
  output eth_metadata_t m_meta,
  output logic          m_meta_valid,
  input  logic          m_meta_ready,
  output logic [7:0]    p_tdata,
  output logic          p_tvalid,
  input  logic          p_tready,
  output logic          p_tlast,
  output logic          runt_err
`ifdef ETH_PARSER_STATS_EN
  ,
  output logic [STATS_W-1:0] stat_frames,
  output logic [STATS_W-1:0] stat_runts,
  output logic [STATS_W-1:0] stat_vlan
`endif
);

  function automatic logic in_field(input logic [4:0] cnt, input logic [4:0] lo,
                                    input logic [4:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  parser_state_t r_state, w_state_nxt;
  logic [4:0]    r_byte_cnt;
  mac_addr_t     r_dest_mac, r_src_mac;
  ethertype_t    r_outer_type, r_tci, r_inner_type;
  logic          r_runt_err;

  logic          w_accept, w_hdr_acc, w_last_plain, w_last_vlan;
  logic          w_hdr_done, w_runt;
  ethertype_t    w_outer_type;
  eth_metadata_t w_meta_nxt;

  assign w_accept  = s_tvalid & s_tready;
  assign w_hdr_acc = w_accept & (r_state == HDR);

  // On byte 13 the outer type is only half-registered; merge the live byte.
  assign w_outer_type = {r_outer_type[7:0], s_tdata};
  assign w_last_plain = (r_byte_cnt == ETH_HDR_LEN - 5'd1) &&
                        (w_outer_type != ETHERTYPE_VLAN);
  assign w_last_vlan  = (r_byte_cnt == ETH_HDR_LEN_VLAN - 5'd1);
  assign w_hdr_done   = w_hdr_acc & (w_last_plain | w_last_vlan);
  assign w_runt       = w_hdr_acc & s_tlast & ~w_hdr_done;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HDR;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HDR:     if (w_hdr_done && !s_tlast) w_state_nxt = PAYLOAD;
      PAYLOAD: if (w_accept && s_tlast)    w_state_nxt = HDR;
      default: w_state_nxt = HDR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    s_tready = 1'b0;
    p_tvalid = 1'b0;
    p_tlast  = 1'b0;
    p_tdata  = s_tdata;
    if (!rst) begin
      case (r_state)
        HDR:     s_tready = ~m_meta_valid;
        PAYLOAD: begin
          s_tready = p_tready;
          p_tvalid = s_tvalid;
          p_tlast  = s_tlast;
        end
        default: s_tready = 1'b0;
      endcase
    end
  end

  // ---------------- header byte capture ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt   <= '0;
      r_dest_mac   <= '0;
      r_src_mac    <= '0;
      r_outer_type <= '0;
      r_tci        <= '0;
      r_inner_type <= '0;
      r_runt_err   <= 1'b0;
    end else begin
      r_runt_err <= w_runt;
      if (w_hdr_done || w_runt) begin
        r_byte_cnt <= '0;
      end else if (w_hdr_acc) begin
        r_byte_cnt <= r_byte_cnt + 5'd1;
      end
      if (w_hdr_acc) begin
        if (in_field(r_byte_cnt, ETH_OFF_DA, ETH_OFF_SA))
          r_dest_mac <= {r_dest_mac[39:0], s_tdata};
        if (in_field(r_byte_cnt, ETH_OFF_SA, ETH_OFF_TYPE))
          r_src_mac <= {r_src_mac[39:0], s_tdata};
        if (in_field(r_byte_cnt, ETH_OFF_TYPE, ETH_OFF_TCI))
          r_outer_type <= {r_outer_type[7:0], s_tdata};
        if (in_field(r_byte_cnt, ETH_OFF_TCI, ETH_OFF_INNER_TYPE))
          r_tci <= {r_tci[7:0], s_tdata};
        if (in_field(r_byte_cnt, ETH_OFF_INNER_TYPE, ETH_HDR_LEN_VLAN))
          r_inner_type <= {r_inner_type[7:0], s_tdata};
      end
    end
  end

  // Metadata assembled from registered fields plus the final live byte.
  always_comb begin
    w_meta_nxt          = '0;
    w_meta_nxt.dest_mac = r_dest_mac;
    w_meta_nxt.src_mac  = r_src_mac;
    if (w_last_vlan) begin
      w_meta_nxt.ethertype     = {r_inner_type[7:0], s_tdata};
      w_meta_nxt.vlan_present  = 1'b1;
      w_meta_nxt.vlan_id       = r_tci[11:0];
      w_meta_nxt.l2_header_len = ETH_HDR_LEN_VLAN;
    end else begin
      w_meta_nxt.ethertype     = w_outer_type;
      w_meta_nxt.l2_header_len = ETH_HDR_LEN;
    end
    w_meta_nxt.cls = classify_ethertype(w_meta_nxt.ethertype);
  end

  eth_meta_reg #(
    .WIDTH ($bits(eth_metadata_t))
  ) u_meta_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (w_hdr_done),
    .load_data (w_meta_nxt),
    .data      (m_meta),
    .valid     (m_meta_valid),
    .ready     (m_meta_ready)
  );

  assign runt_err = r_runt_err;

`ifdef ETH_PARSER_STATS_EN
  logic               w_meta_hs;
  logic [STATS_W-1:0] r_stat_frames, r_stat_runts, r_stat_vlan;

  assign w_meta_hs = m_meta_valid & m_meta_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_frames <= '0;
      r_stat_runts  <= '0;
      r_stat_vlan   <= '0;
    end else begin
      if (w_meta_hs && (r_stat_frames != '1))
        r_stat_frames <= r_stat_frames + STATS_W'(1);
      if (r_runt_err && (r_stat_runts != '1))
        r_stat_runts <= r_stat_runts + STATS_W'(1);
      if (w_meta_hs && m_meta.vlan_present && (r_stat_vlan != '1))
        r_stat_vlan <= r_stat_vlan + STATS_W'(1);
    end
  end

  assign stat_frames = r_stat_frames;
  assign stat_runts  = r_stat_runts;
  assign stat_vlan   = r_stat_vlan;
`else
  localparam int unused_stats_w = STATS_W;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eth_header_parser.sv
// ============================================================================
//  Module  : tb_eth_header_parser
//  Purpose : Self-checking bench for eth_header_parser. Expected metadata and
//            payload bytes are derived from each frame's byte list and queued
//            before driving; monitors pop and compare on every handshake.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_header_parser;
  import eth_parser_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_tdata;
  logic          s_tvalid, s_tlast;
  logic          s_tready;
  eth_metadata_t m_meta;
  logic          m_meta_valid;
  logic          m_meta_ready;
  logic [7:0]    p_tdata;
  logic          p_tvalid, p_tlast;
  logic          p_tready = 1'b1;
  logic          runt_err;
`ifdef ETH_PARSER_STATS_EN
  logic [31:0]   stat_frames, stat_runts, stat_vlan;
`endif

  always #5 clk = ~clk;

  eth_header_parser #(.STATS_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .m_meta       (m_meta),
    .m_meta_valid (m_meta_valid),
    .m_meta_ready (m_meta_ready),
    .p_tdata      (p_tdata),
    .p_tvalid     (p_tvalid),
    .p_tready     (p_tready),
    .p_tlast      (p_tlast),
    .runt_err     (runt_err)
`ifdef ETH_PARSER_STATS_EN
    ,
    .stat_frames  (stat_frames),
    .stat_runts   (stat_runts),
    .stat_vlan    (stat_vlan)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  eth_metadata_t meta_q[$];
  logic [8:0]    pay_q[$];
  int meta_exp = 0, meta_seen = 0, pay_exp = 0, pay_seen = 0;
  int runt_exp = 0, runt_seen = 0;
  logic          rand_p = 1'b0;

  eth_metadata_t mon_e, mon_prev;
  logic [8:0]    mon_p;
  logic          mon_hold = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_hold = 1'b0;
    end else begin
      if (mon_hold && m_meta_valid)
        check("meta_stable", 64'(m_meta == mon_prev), 64'd1);
      mon_hold = m_meta_valid && !m_meta_ready;
      mon_prev = m_meta;
      if (m_meta_valid && m_meta_ready) begin
        meta_seen++;
        if (meta_q.size() > 0) begin
          mon_e = meta_q.pop_front();
          check("dest_mac",  64'(m_meta.dest_mac),      64'(mon_e.dest_mac));
          check("src_mac",   64'(m_meta.src_mac),       64'(mon_e.src_mac));
          check("ethertype", 64'(m_meta.ethertype),     64'(mon_e.ethertype));
          check("vlan",      64'({m_meta.vlan_present, m_meta.vlan_id}),
                             64'({mon_e.vlan_present, mon_e.vlan_id}));
          check("hdr_len",   64'(m_meta.l2_header_len), 64'(mon_e.l2_header_len));
          check("class",     64'(m_meta.cls),           64'(mon_e.cls));
        end
      end
      if (p_tvalid && p_tready) begin
        pay_seen++;
        if (pay_q.size() > 0) begin
          mon_p = pay_q.pop_front();
          check("payload", 64'({p_tlast, p_tdata}), 64'(mon_p));
        end
      end
      if (runt_err) runt_seen++;
    end
  end

  // p_tready is either held high or toggled randomly, changed after posedge.
  always @(posedge clk) begin
    #1;
    p_tready = rand_p ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver ----------------
  logic [7:0] fr[$];

  function automatic logic [3:0] exp_class(input logic [15:0] t);
    // {ipv4, ipv6, arp, unknown}
    if (t == 16'h0800) return 4'b1000;
    if (t == 16'h86DD) return 4'b0100;
    if (t == 16'h0806) return 4'b0010;
    return 4'b0001;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last);
    logic acc;
    acc = 1'b0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    for (int k = 0; k < 500 && !acc; k++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic build_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] t);
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(sa[47-8*i -: 8]);
    fr.push_back(t[15:8]);
    fr.push_back(t[7:0]);
  endtask

  task automatic add_payload(input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) fr.push_back(8'(seed + 8'(i)));
  endtask

  task automatic send_frame();
    int n, hl;
    logic runt;
    eth_metadata_t em;
    n  = fr.size();
    hl = (n >= 14 && {fr[12], fr[13]} == 16'h8100) ? 18 : 14;
    runt = (n < hl);
    if (!runt) begin
      em = '0;
      for (int i = 0; i < 6; i++) begin
        em.dest_mac = {em.dest_mac[39:0], fr[i]};
        em.src_mac  = {em.src_mac[39:0], fr[i+6]};
      end
      if (hl == 18) begin
        em.ethertype    = {fr[16], fr[17]};
        em.vlan_present = 1'b1;
        em.vlan_id      = {fr[14][3:0], fr[15]};
      end else begin
        em.ethertype = {fr[12], fr[13]};
      end
      em.l2_header_len = 5'(hl);
      em.cls = eth_class_t'(exp_class(em.ethertype));
      meta_q.push_back(em);
      meta_exp++;
      for (int i = hl; i < n; i++) begin
        pay_q.push_back({(i == n - 1), fr[i]});
        pay_exp++;
      end
    end else begin
      runt_exp++;
    end
    for (int i = 0; i < n; i++) begin
      if (!runt && i == hl - 1 && m_meta_ready)
        check("meta_pre", 64'(m_meta_valid), 64'd0);
      send_byte(fr[i], (i == n - 1));
      if (!runt && i == hl - 1)
        check("meta_lat", 64'(m_meta_valid), 64'd1);
      if (i == n - 1) begin
        if (runt) begin
          check("runt_pulse", 64'(runt_err), 64'd1);
          check("runt_no_meta", 64'(m_meta_valid), 64'd0);
          @(posedge clk);
          #1;
          check("runt_once", 64'(runt_err), 64'd0);
        end else begin
          check("no_runt", 64'(runt_err), 64'd0);
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
`ifdef ETH_PARSER_STATS_EN
  logic [31:0] f0;
`endif

  initial begin
    rst = 1'b1;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_meta_ready = 1'b1;
    @(negedge clk);
    check("rst_s_tready",  64'(s_tready),     64'd0);
    check("rst_p_tvalid",  64'(p_tvalid),     64'd0);
    check("rst_meta_vld",  64'(m_meta_valid), 64'd0);
    check("rst_runt",      64'(runt_err),     64'd0);
    check("rst_meta_zero", 64'(m_meta == '0), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Untagged IPv4, 4 payload bytes.
    build_hdr(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800);
    add_payload(4, 8'hA0);
    send_frame();

    // Single tag, TCI 0x2064, inner IPv6.
    build_hdr(48'h112233445566, 48'h778899AABBCC, 16'h8100);
    fr.push_back(8'h20); fr.push_back(8'h64);
    fr.push_back(8'h86); fr.push_back(8'hDD);
    add_payload(3, 8'h30);
    send_frame();

    // Runt: last on byte 9, then a good frame.
    build_hdr(48'hDEADBEEF0001, 48'h000000000002, 16'h0800);
    fr = fr[0:9];
    send_frame();
    build_hdr(48'hFFFFFFFFFFFF, 48'h00AA00BB00CC, 16'h0800);
    add_payload(2, 8'h55);
    send_frame();

    // Metadata backpressure across two back-to-back ARP frames.
    m_meta_ready = 1'b0;
    build_hdr(48'h0000000000A1, 48'h0000000000B1, 16'h0806);
    add_payload(2, 8'h10);
    send_frame();
    s_tdata = 8'hC1; s_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("hdr_stall", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    m_meta_ready = 1'b1;
    build_hdr(48'hC10000000002, 48'h0000000000B2, 16'h0806);
    add_payload(3, 8'h20);
    send_frame();

    // Random payload backpressure.
    rand_p = 1'b1;
    build_hdr(48'h020000000001, 48'h020000000002, 16'h0800);
    for (int i = 0; i < 20; i++) fr.push_back(8'($urandom_range(0, 255)));
    send_frame();
    rand_p = 1'b0;
    @(posedge clk); #1;

    // QinQ is unsupported: inner 0x8100 classifies as unknown.
    build_hdr(48'h030000000001, 48'h030000000002, 16'h8100);
    fr.push_back(8'h0F); fr.push_back(8'hFF);
    fr.push_back(8'h81); fr.push_back(8'h00);
    add_payload(2, 8'h70);
    send_frame();

    // Header-only frame.
`ifdef ETH_PARSER_STATS_EN
    f0 = stat_frames;
`endif
    build_hdr(48'h040000000001, 48'h040000000002, 16'h0806);
    send_frame();
    repeat (3) @(posedge clk); #1;
`ifdef ETH_PARSER_STATS_EN
    check("stat_frames", 64'(stat_frames), 64'(f0 + 32'd1));
`endif

    // Reset in the middle of a header: discarded, no runt.
    build_hdr(48'h050000000001, 48'h050000000002, 16'h0800);
    for (int i = 0; i < 5; i++) send_byte(fr[i], 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_s_tready", 64'(s_tready), 64'd0);
    check("mid_rst_p_tvalid", 64'(p_tvalid), 64'd0);
    repeat (2) @(posedge clk); #1;
    check("mid_rst_runt", 64'(runt_err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Unknown ethertype after reset.
    build_hdr(48'h060000000001, 48'h060000000002, 16'h1234);
    add_payload(2, 8'hE0);
    send_frame();

    repeat (5) @(posedge clk); #1;
    check("meta_count", 64'(meta_seen), 64'(meta_exp));
    check("pay_count",  64'(pay_seen),  64'(pay_exp));
    check("runt_count", 64'(runt_seen), 64'(runt_exp));
    check("meta_q_left", 64'(meta_q.size()), 64'd0);
    check("pay_q_left",  64'(pay_q.size()),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/eth_header_parser.md
Name: eth_header_parser

Overview:
- L2 front-end stage: consumes a byte-wide Ethernet frame stream and extracts DA, SA, optional single 802.1Q tag and EtherType.
- Fills eth_metadata_t for downstream classification stages.
- Forwards the remaining payload bytes as a separate stream.
- Sits between the MAC RX byte interface and the L3 dispatch logic.

Parameters:
- STATS_W, 32, width of the optional statistics counters (only used with ETH_PARSER_STATS_EN)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- s_tdata  in  8  frame byte, first byte = DA[47:40]
- s_tvalid  in  1  input byte valid
- s_tready  out  1  input byte accepted when s_tvalid & s_tready
- s_tlast  in  1  last byte of frame
- m_meta  out  $bits(eth_metadata_t)  parsed metadata
- m_meta_valid  out  1  metadata valid
- m_meta_ready  in  1  downstream accepts metadata
- p_tdata  out  8  payload byte
- p_tvalid  out  1  payload valid
- p_tready  in  1  payload accept
- p_tlast  out  1  last payload byte
- runt_err  out  1  one-cycle pulse: frame ended before header complete

Behaviour:
- Reset values: state=HDR, byte_cnt=0, m_meta=0, m_meta_valid=0, runt_err=0. p_tvalid=0 and s_tready=0 while rst is high.
- States:
  - HDR: collect header bytes.
  - PAYLOAD: pass-through.
- HDR handshake:
  - s_tready = ~m_meta_valid, i.e. a new header is not accepted until the previous metadata is consumed.
  - p_tvalid=0.
- Byte capture by byte_cnt (5 bits, incremented per accepted byte):
  - bytes 0-5 -> dest_mac, MSB first.
  - bytes 6-11 -> src_mac.
  - bytes 12-13 -> outer type.
  - If outer type == ETHERTYPE_VLAN:
    - bytes 14-15 -> TCI; vlan_id = TCI[11:0].
    - bytes 16-17 -> inner ethertype.
    - vlan_present=1, l2_header_len=18.
  - Otherwise: header ends at byte 13, vlan_present=0, vlan_id=0, l2_header_len=14.
- Classification on the resolved ethertype:
  - is_ipv4 if 0x0800, is_arp if 0x0806, is_ipv6 if 0x86DD.
  - Otherwise is_unknown=1. This includes an inner 0x8100 (QinQ is unsupported).
  - Exactly one classification flag is set.
- Metadata output:
  - m_meta_valid rises the cycle after the last header byte is accepted; m_meta is stable while valid.
  - Cleared on m_meta_valid & m_meta_ready.
  - Then state -> PAYLOAD, unless the last header byte carried s_tlast.
- Header-only frame (s_tlast on the final header byte): metadata is emitted, no payload bytes, state stays HDR.
- Runt (s_tlast accepted with byte_cnt < required header length):
  - runt_err pulses the next cycle; no metadata; byte_cnt=0; state stays HDR.
- PAYLOAD: combinational pass-through.
  - p_tdata=s_tdata, p_tvalid=s_tvalid, p_tlast=s_tlast, s_tready=p_tready.
  - On an accepted byte with s_tlast: state -> HDR, byte_cnt=0.
- Payload may flow while m_meta_valid is still pending. The next frame's header stalls until the metadata is accepted.
- Frame-level latency: metadata 1 cycle after the header end; payload 0 added cycles.
- Reset mid-frame: immediate return to reset values. A partial frame is discarded, with no runt_err.

Optional Feature:
- Macro: ETH_PARSER_STATS_EN.
- When defined, adds these outputs, each STATS_W bits:
  - stat_frames: increments on each metadata handshake.
  - stat_runts: increments on each runt_err.
  - stat_vlan: increments on each handshake with vlan_present=1.
- Counters saturate at all-ones and clear on rst.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Add to eth_parser_pkg:
  - parser_state_t enum {HDR, PAYLOAD}.
  - Byte-offset constants ETH_OFF_DA=0, ETH_OFF_SA=6, ETH_OFF_TYPE=12, ETH_OFF_TCI=14, ETH_OFF_INNER_TYPE=16.
  - Function classify_ethertype(ethertype_t) that sets the classification flags.
- One natural sub-module, eth_meta_reg: the metadata holding register with valid/ready. It is reusable by later stages.

Test Plan:
- Untagged IPv4 frame, DA=01:02:03:04:05:06, SA=0A:0B:0C:0D:0E:0F, type 0x0800, 4 payload bytes, all ready=1:
  - m_meta_valid on the cycle after byte 13.
  - is_ipv4=1, l2_header_len=14, vlan_present=0.
  - p_tvalid for exactly 4 bytes, p_tlast on the 4th.
- Tagged frame, type 0x8100, TCI=0x2064, inner 0x86DD:
  - vlan_present=1, vlan_id=0x064, ethertype=0x86DD, is_ipv6=1, l2_header_len=18.
  - First payload byte = input byte 18.
- Runt: s_tlast on byte 9 -> runt_err pulse 1 cycle, no m_meta_valid. The next good frame parses correctly.
- Backpressure:
  - Hold m_meta_ready=0 across two back-to-back ARP (0x0806) frames; s_tready stays 0 at the second frame's byte 0.
  - After m_meta_ready=1, second metadata is_arp=1 and no bytes are lost.
  - Random p_tready toggling preserves the payload byte order.
- QinQ: outer 0x8100 and inner 0x8100 -> is_unknown=1, l2_header_len=18.
- Header-only frame (s_tlast on byte 13) -> metadata emitted, zero p_tvalid cycles. With ETH_PARSER_STATS_EN, stat_frames increments by 1.
